// File: rtl/layer0_input_packer_if.sv
// rtl/layer0_input_packer_if.sv - sample-in / frame-out handshake bundle for the layer-0 input packer
interface layer0_input_packer_if #(
  parameter int SAMPLE_W = 12,
  parameter int NUM_FEAT = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [SAMPLE_W-1:0]   s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [2*NUM_FEAT-1:0] m_data;

  // Feeder side: drives samples, accepts frames.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  // Packer side: accepts samples, drives frames.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/layer0_input_packer.sv
// rtl/layer0_input_packer.sv - thermometer-quantize samples and pack them into double-buffered layer-0 frames
module layer0_input_packer #(
  parameter int SAMPLE_W = 12,
  parameter int NUM_FEAT = 32,
  parameter int TH0      = -512,
  parameter int TH1      = 0,
  parameter int TH2      = 512,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  layer0_input_packer_if.slave   bus,
  output logic                   err,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic signed [SAMPLE_W-1:0] TH0_S = SAMPLE_W'(TH0);
  localparam logic signed [SAMPLE_W-1:0] TH1_S = SAMPLE_W'(TH1);
  localparam logic signed [SAMPLE_W-1:0] TH2_S = SAMPLE_W'(TH2);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [2*NUM_FEAT-1:0] fill_buf;
  logic [2*NUM_FEAT-1:0] frame_word;
  logic [1:0]            code;
  logic                  accept;
  logic                  load_frame;
  logic                  load_buf;
  logic                  err_d;
  logic                  drop;
  logic                  m_valid_d;

  assign bus.s_ready = (state == FILL);
  assign accept      = bus.s_valid & bus.s_ready;

  // Thermometer code; a sample equal to a threshold takes the upper code.
  always_comb begin
    code = 2'd0;
    if ($signed(bus.s_data) >= TH2_S)
      code = 2'd3;
    else if ($signed(bus.s_data) >= TH1_S)
      code = 2'd2;
    else if ($signed(bus.s_data) >= TH0_S)
      code = 2'd1;
  end

  // A completing frame bypasses the buffer so the final code lands in m_data on the same edge.
  always_comb begin
    frame_word = fill_buf;
    frame_word[2*NUM_FEAT-1 -: 2] = code;
  end

  // Fill buffer: every slot is rewritten each frame, so it never needs clearing.
  always_ff @(posedge clk) begin
    if (accept)
      fill_buf[{idx, 1'b0} +: 2] <= code;
  end

  // Next-state, slot index and frame/drop decisions.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    load_frame = 1'b0;
    load_buf   = 1'b0;
    err_d      = 1'b0;
    drop       = 1'b0;
    m_valid_d  = bus.m_valid & ~bus.m_ready;
    case (state)
      FILL: begin
        if (accept) begin
          if (bus.s_last != (idx == LAST_IDX)) begin
            idx_d = '0;
            err_d = 1'b1;
            drop  = 1'b1;
          end else if (bus.s_last) begin
            idx_d = '0;
            if (!bus.m_valid || bus.m_ready) begin
              load_frame = 1'b1;
              m_valid_d  = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (bus.m_valid && bus.m_ready) begin
          load_buf  = 1'b1;
          m_valid_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register and fill index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Output frame register and one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      err         <= 1'b0;
    end else begin
      bus.m_valid <= m_valid_d;
      err         <= err_d;
      if (load_frame)
        bus.m_data <= frame_word;
      else if (load_buf)
        bus.m_data <= fill_buf;
    end
  end

  // Saturating status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if ((load_frame || load_buf) && (frame_cnt != {CNT_W{1'b1}}))
        frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_layer0_input_packer.sv
// tb/tb_layer0_input_packer.sv - randomized and directed bench for layer0_input_packer against a frame-level model
module tb_layer0_input_packer;
  localparam int SAMPLE_W = 12;
  localparam int NUM_FEAT = 32;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  layer0_input_packer_if #(.SAMPLE_W(SAMPLE_W), .NUM_FEAT(NUM_FEAT)) bus ();

  layer0_input_packer #(
    .SAMPLE_W(SAMPLE_W), .NUM_FEAT(NUM_FEAT),
    .TH0(-512), .TH1(0), .TH2(512), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .err(err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level view of what layer 0 should see.
  int          cur[$];
  bit          out_v;
  logic [63:0] out_w;
  bit          held;
  logic [63:0] held_w;
  bit          err_e;
  int          fcnt;
  int          dcnt;

  // Driven stimulus, mirrored for the model.
  bit d_valid, d_last, d_ready;
  int d_x;

  function automatic int quant(input int x);
    if (x >= 512) return 3;
    if (x >= 0)   return 2;
    if (x >= -512) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    cur.delete();
    out_v  = 1'b0;
    out_w  = '0;
    held   = 1'b0;
    held_w = '0;
    err_e  = 1'b0;
    fcnt   = 0;
    dcnt   = 0;
  endtask

  task automatic drive(input bit v, input int x, input bit last, input bit rdy);
    d_valid = v; d_x = x; d_last = last; d_ready = rdy;
    bus.s_valid = v;
    bus.s_data  = SAMPLE_W'(x);
    bus.s_last  = last;
    bus.m_ready = rdy;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit drained;
    @(negedge clk);
    check_val("s_ready", 64'(bus.s_ready), 64'(!held));
    check_val("m_valid", 64'(bus.m_valid), 64'(out_v));
    if (out_v) check_val("m_data", bus.m_data, out_w);
    check_val("err", 64'(err), 64'(err_e));
    check_val("frame_cnt", 64'(frame_cnt), 64'(fcnt));
    check_val("drop_cnt", 64'(drop_cnt), 64'(dcnt));
    err_e   = 1'b0;
    drained = out_v && d_ready;
    if (drained) out_v = 1'b0;
    if (held) begin
      if (drained) begin
        out_w = held_w; out_v = 1'b1; held = 1'b0; fcnt = sat_inc(fcnt);
      end
    end else if (d_valid) begin
      cur.push_back(quant(d_x));
      if (d_last && cur.size() == NUM_FEAT) begin
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
          int c;
          c = cur[k];
          w[2*k +: 2] = c[1:0];
        end
        cur.delete();
        if (!out_v) begin
          out_w = w; out_v = 1'b1; fcnt = sat_inc(fcnt);
        end else begin
          held = 1'b1; held_w = w;
        end
      end else if (d_last || cur.size() == NUM_FEAT) begin
        cur.delete();
        err_e = 1'b1;
        dcnt  = sat_inc(dcnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  int pat[8] = '{-513, -512, -1, 0, 511, 512, 2047, -2048};
  logic [63:0] f1, f2;

  initial begin
    drive(0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_s_ready", 64'(bus.s_ready), 64'd1);
    check_val("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check_val("rst_m_data", bus.m_data, 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // All-zero frame: every code is 2.
    for (int i = 0; i < NUM_FEAT; i++) begin drive(1, 0, i == NUM_FEAT-1, 1); cycle(); end
    check_val("t1_data", bus.m_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check_val("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    drive(0, 0, 0, 1); cycle();

    // Threshold boundaries.
    for (int i = 0; i < NUM_FEAT; i++) begin drive(1, pat[i % 8], i == NUM_FEAT-1, 1); cycle(); end
    check_val("t2_data", bus.m_data, 64'h3E94_3E94_3E94_3E94);
    check_val("t2_frame_cnt", 64'(frame_cnt), 64'd2);
    drive(0, 0, 0, 1); cycle();

    // Backpressure: two frames with m_ready low.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NUM_FEAT; i++) begin drive(1, rand_sample(), i == NUM_FEAT-1, 0); cycle(); end
      if (f == 0) f1 = out_w; else f2 = held_w;
    end
    check_val("t3_s_ready_low", 64'(bus.s_ready), 64'd0);
    check_val("t3_hold_data", bus.m_data, f1);
    drive(0, 0, 0, 0);
    repeat (3) cycle();
    check_val("t3_still_held", bus.m_data, f1);
    drive(0, 0, 0, 1); cycle();
    check_val("t3_frame2", bus.m_data, f2);
    check_val("t3_s_ready_back", 64'(bus.s_ready), 64'd1);
    check_val("t3_m_valid", 64'(bus.m_valid), 64'd1);
    cycle();

    // Early s_last.
    for (int i = 0; i <= 10; i++) begin drive(1, rand_sample(), i == 10, 1); cycle(); end
    check_val("t4_err", 64'(err), 64'd1);
    check_val("t4_drop_cnt", 64'(drop_cnt), 64'd1);
    check_val("t4_no_valid", 64'(bus.m_valid), 64'd0);
    drive(0, 0, 0, 1); cycle();
    check_val("t4_err_pulse", 64'(err), 64'd0);
    for (int i = 0; i < NUM_FEAT; i++) begin drive(1, rand_sample(), i == NUM_FEAT-1, 1); cycle(); end
    check_val("t4_next_frame", 64'(bus.m_valid), 64'd1);
    drive(0, 0, 0, 1); cycle();

    // Missing s_last.
    for (int i = 0; i < NUM_FEAT; i++) begin drive(1, rand_sample(), 0, 1); cycle(); end
    check_val("t5_err", 64'(err), 64'd1);
    check_val("t5_drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < NUM_FEAT; i++) begin drive(1, rand_sample(), i == NUM_FEAT-1, 1); cycle(); end
    check_val("t5_realign", 64'(bus.m_valid), 64'd1);
    drive(0, 0, 0, 1); cycle();

    // Asynchronous reset while FULL.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NUM_FEAT; i++) begin drive(1, rand_sample(), i == NUM_FEAT-1, 0); cycle(); end
    drive(0, 0, 0, 0); cycle();
    check_val("t6_in_full", 64'(bus.s_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_s_ready", 64'(bus.s_ready), 64'd1);
    check_val("t6_m_valid", 64'(bus.m_valid), 64'd0);
    check_val("t6_m_data", bus.m_data, 64'd0);
    check_val("t6_err", 64'(err), 64'd0);
    check_val("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    check_val("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Drop counter saturation.
    for (int i = 0; i < CNT_MAX + 5; i++) begin drive(1, rand_sample(), 1, 1); cycle(); end
    check_val("sat_drop", 64'(drop_cnt), 64'(CNT_MAX));

    // Random traffic with occasional framing errors and backpressure.
    for (int n = 0; n < 3000; n++) begin
      bit v, rdy, last;
      int x;
      v    = ($urandom_range(0, 9) < 8);
      rdy  = ($urandom_range(0, 9) < 6);
      last = (cur.size() == NUM_FEAT - 1);
      if ($urandom_range(0, 199) == 0) last = !last;
      x = ($urandom_range(0, 3) == 0) ? pat[$urandom_range(0, 7)] : rand_sample();
      drive(v, x, last, rdy);
      cycle();
    end
    drive(0, 0, 0, 1);
    repeat (4) cycle();
    check_val("sat_frame", 64'(frame_cnt), 64'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
